// File: rtl/cpu_pkg.sv
// Shared types for the SAP-style control unit: opcodes, micro-steps and the control word.
// Control word bits map one-to-one onto the cpu_control output ports.
package cpu_pkg;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_LDA = 4'h1,
      OP_ADD = 4'h2,
      OP_SUB = 4'h3,
      OP_STA = 4'h4,
      OP_LDI = 4'h5,
      OP_JMP = 4'h6,
      OP_JC  = 4'h7,
      OP_JZ  = 4'h8,
      OP_OUT = 4'hE,
      OP_HLT = 4'hF
   } opcode_e;

   typedef enum logic [2:0] {
      T0 = 3'd0,
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3,
      T4 = 3'd4
   } step_e;

   typedef struct packed {
      logic clk_halt;
      logic pc_inc;
      logic pc_jump;
      logic pc_out;
      logic a_reg_read_from_bus;
      logic a_reg_write_to_bus;
      logic b_reg_read_from_bus;
      logic b_reg_write_to_bus;
      logic i_reg_read_from_bus;
      logic i_reg_write_to_bus;
      logic mar_read_from_bus;
      logic ram_read_from_bus;
      logic ram_write_to_bus;
      logic alu_out;
      logic alu_subtract;
      logic alu_flags_in;
      logic out_en;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = '0;

   localparam ctrl_t FETCH_T0 = '{pc_out: 1'b1, mar_read_from_bus: 1'b1, default: 1'b0};

   localparam ctrl_t FETCH_T1 = '{ram_write_to_bus: 1'b1, i_reg_read_from_bus: 1'b1,
                                  pc_inc: 1'b1, default: 1'b0};

endpackage

// File: rtl/cpu_step_counter.sv
// Micro-step counter T0..T4 with sticky halt; advances every rising clk, frozen at T2 once halted.
// Asynchronous active-low reset returns to T0 and clears halt.
module cpu_step_counter
   import cpu_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  hlt_req,
   output step_e step,
   output logic  halted
);

   step_e step_q, step_d;
   logic  halted_q, halted_d;

   always_comb begin
      step_d   = step_q;
      halted_d = halted_q;
      if (!halted_q) begin
         case (step_q)
            T0: step_d = T1;
            T1: step_d = T2;
            // HLT parks the counter on T2 rather than advancing.
            T2: begin
               if (hlt_req) halted_d = 1'b1;
               else         step_d   = T3;
            end
            T3: step_d = T4;
            T4: step_d = T0;
            default: step_d = T0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         step_q   <= T0;
         halted_q <= 1'b0;
      end else begin
         step_q   <= step_d;
         halted_q <= halted_d;
      end
   end

   assign step   = step_q;
   assign halted = halted_q;

endmodule

// File: rtl/cpu_control.sv
// Microcoded control unit: decodes opcode + micro-step (+ latched flags) into one-hot control lines.
// Outputs are combinational; all forced low while rst is low, only clk_halt while halted.
module cpu_control
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] instruction,
   input  logic       alu_carry,
   input  logic       alu_zero,
   output logic       clk_halt,
   output logic       pc_inc,
   output logic       pc_jump,
   output logic       pc_out,
   output logic       a_reg_read_from_bus,
   output logic       a_reg_write_to_bus,
   output logic       b_reg_read_from_bus,
   output logic       b_reg_write_to_bus,
   output logic       i_reg_read_from_bus,
   output logic       i_reg_write_to_bus,
   output logic       mar_read_from_bus,
   output logic       ram_read_from_bus,
   output logic       ram_write_to_bus,
   output logic       alu_out,
   output logic       alu_subtract,
   output logic       alu_flags_in,
   output logic       out_en
);

   step_e step;
   logic  halted;
   ctrl_t ctrl;

   cpu_step_counter u_step_counter (
      .clk     (clk),
      .rst     (rst),
      .hlt_req (instruction == OP_HLT),
      .step    (step),
      .halted  (halted)
   );

   always_comb begin
      ctrl = CTRL_NONE;
      if (!rst) begin
         ctrl = CTRL_NONE;
      end else if (halted) begin
         ctrl.clk_halt = 1'b1;
      end else begin
         case (step)
            T0: ctrl = FETCH_T0;
            T1: ctrl = FETCH_T1;
            T2: begin
               case (instruction)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     ctrl.i_reg_write_to_bus = 1'b1;
                     ctrl.mar_read_from_bus  = 1'b1;
                  end
                  OP_LDI: begin
                     ctrl.i_reg_write_to_bus  = 1'b1;
                     ctrl.a_reg_read_from_bus = 1'b1;
                  end
                  OP_JMP: begin
                     ctrl.i_reg_write_to_bus = 1'b1;
                     ctrl.pc_jump            = 1'b1;
                  end
                  // Conditional jumps follow the live flag value within the cycle.
                  OP_JC: begin
                     ctrl.i_reg_write_to_bus = alu_carry;
                     ctrl.pc_jump            = alu_carry;
                  end
                  OP_JZ: begin
                     ctrl.i_reg_write_to_bus = alu_zero;
                     ctrl.pc_jump            = alu_zero;
                  end
                  OP_OUT: begin
                     ctrl.a_reg_write_to_bus = 1'b1;
                     ctrl.out_en             = 1'b1;
                  end
                  OP_HLT:  ctrl.clk_halt = 1'b1;
                  default: ctrl = CTRL_NONE;
               endcase
            end
            T3: begin
               case (instruction)
                  OP_LDA: begin
                     ctrl.ram_write_to_bus    = 1'b1;
                     ctrl.a_reg_read_from_bus = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     ctrl.ram_write_to_bus    = 1'b1;
                     ctrl.b_reg_read_from_bus = 1'b1;
                  end
                  OP_STA: begin
                     ctrl.a_reg_write_to_bus = 1'b1;
                     ctrl.ram_read_from_bus  = 1'b1;
                  end
                  default: ctrl = CTRL_NONE;
               endcase
            end
            T4: begin
               if (instruction == OP_ADD || instruction == OP_SUB) begin
                  ctrl.alu_out             = 1'b1;
                  ctrl.a_reg_read_from_bus = 1'b1;
                  ctrl.alu_flags_in        = 1'b1;
                  ctrl.alu_subtract        = (instruction == OP_SUB);
               end
            end
            default: ctrl = CTRL_NONE;
         endcase
      end
   end

   assign clk_halt            = ctrl.clk_halt;
   assign pc_inc              = ctrl.pc_inc;
   assign pc_jump             = ctrl.pc_jump;
   assign pc_out              = ctrl.pc_out;
   assign a_reg_read_from_bus = ctrl.a_reg_read_from_bus;
   assign a_reg_write_to_bus  = ctrl.a_reg_write_to_bus;
   assign b_reg_read_from_bus = ctrl.b_reg_read_from_bus;
   assign b_reg_write_to_bus  = ctrl.b_reg_write_to_bus;
   assign i_reg_read_from_bus = ctrl.i_reg_read_from_bus;
   assign i_reg_write_to_bus  = ctrl.i_reg_write_to_bus;
   assign mar_read_from_bus   = ctrl.mar_read_from_bus;
   assign ram_read_from_bus   = ctrl.ram_read_from_bus;
   assign ram_write_to_bus    = ctrl.ram_write_to_bus;
   assign alu_out             = ctrl.alu_out;
   assign alu_subtract        = ctrl.alu_subtract;
   assign alu_flags_in        = ctrl.alu_flags_in;
   assign out_en              = ctrl.out_en;

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: randomized opcodes/flags against an instruction-level model.
module tb_cpu_control;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] instruction = 4'h0;
   logic       alu_carry = 1'b0;
   logic       alu_zero = 1'b0;

   logic clk_halt, pc_inc, pc_jump, pc_out;
   logic a_reg_read_from_bus, a_reg_write_to_bus, b_reg_read_from_bus, b_reg_write_to_bus;
   logic i_reg_read_from_bus, i_reg_write_to_bus, mar_read_from_bus;
   logic ram_read_from_bus, ram_write_to_bus, alu_out, alu_subtract, alu_flags_in, out_en;

   cpu_control dut (
      .clk                 (clk),
      .rst                 (rst),
      .instruction         (instruction),
      .alu_carry           (alu_carry),
      .alu_zero            (alu_zero),
      .clk_halt            (clk_halt),
      .pc_inc              (pc_inc),
      .pc_jump             (pc_jump),
      .pc_out              (pc_out),
      .a_reg_read_from_bus (a_reg_read_from_bus),
      .a_reg_write_to_bus  (a_reg_write_to_bus),
      .b_reg_read_from_bus (b_reg_read_from_bus),
      .b_reg_write_to_bus  (b_reg_write_to_bus),
      .i_reg_read_from_bus (i_reg_read_from_bus),
      .i_reg_write_to_bus  (i_reg_write_to_bus),
      .mar_read_from_bus   (mar_read_from_bus),
      .ram_read_from_bus   (ram_read_from_bus),
      .ram_write_to_bus    (ram_write_to_bus),
      .alu_out             (alu_out),
      .alu_subtract        (alu_subtract),
      .alu_flags_in        (alu_flags_in),
      .out_en              (out_en)
   );

   always #5 clk = ~clk;

   // Bench-local bit positions, independent of the RTL control-word layout.
   localparam logic [16:0] HLT  = 17'(1) << 0;
   localparam logic [16:0] PCI  = 17'(1) << 1;
   localparam logic [16:0] JMP  = 17'(1) << 2;
   localparam logic [16:0] PCO  = 17'(1) << 3;
   localparam logic [16:0] AI   = 17'(1) << 4;
   localparam logic [16:0] AO   = 17'(1) << 5;
   localparam logic [16:0] BI   = 17'(1) << 6;
   localparam logic [16:0] BO   = 17'(1) << 7;
   localparam logic [16:0] II   = 17'(1) << 8;
   localparam logic [16:0] IO   = 17'(1) << 9;
   localparam logic [16:0] MI   = 17'(1) << 10;
   localparam logic [16:0] RI   = 17'(1) << 11;
   localparam logic [16:0] RO   = 17'(1) << 12;
   localparam logic [16:0] EO   = 17'(1) << 13;
   localparam logic [16:0] SU   = 17'(1) << 14;
   localparam logic [16:0] FI   = 17'(1) << 15;
   localparam logic [16:0] OI   = 17'(1) << 16;
   localparam logic [16:0] BUS_DRIVERS = PCO | AO | BO | IO | RO | EO;

   logic [16:0] obs;
   assign obs = (clk_halt ? HLT : 17'd0) | (pc_inc ? PCI : 17'd0) | (pc_jump ? JMP : 17'd0)
              | (pc_out ? PCO : 17'd0) | (a_reg_read_from_bus ? AI : 17'd0)
              | (a_reg_write_to_bus ? AO : 17'd0) | (b_reg_read_from_bus ? BI : 17'd0)
              | (b_reg_write_to_bus ? BO : 17'd0) | (i_reg_read_from_bus ? II : 17'd0)
              | (i_reg_write_to_bus ? IO : 17'd0) | (mar_read_from_bus ? MI : 17'd0)
              | (ram_read_from_bus ? RI : 17'd0) | (ram_write_to_bus ? RO : 17'd0)
              | (alu_out ? EO : 17'd0) | (alu_subtract ? SU : 17'd0)
              | (alu_flags_in ? FI : 17'd0) | (out_en ? OI : 17'd0);

   int          m_step = 0;
   bit          m_halted = 1'b0;
   int          vectors = 0;
   int          miscompares = 0;
   logic [16:0] exp_v;

   // Microcode listed per instruction: what each step of that instruction is supposed to do.
   function automatic logic [16:0] model_ctrl();
      logic [16:0] e;
      bit mem_operand;
      e = 17'd0;
      mem_operand = (instruction >= 4'h1 && instruction <= 4'h4);
      if (rst !== 1'b1) return 17'd0;
      if (m_halted) return HLT;
      if (m_step == 0) return PCO | MI;
      if (m_step == 1) return RO | II | PCI;
      if (m_step == 2) begin
         if (mem_operand)                                e = IO | MI;
         else if (instruction == 4'h5)                   e = IO | AI;
         else if (instruction == 4'h6)                   e = IO | JMP;
         else if (instruction == 4'h7 && alu_carry)      e = IO | JMP;
         else if (instruction == 4'h8 && alu_zero)       e = IO | JMP;
         else if (instruction == 4'hE)                   e = AO | OI;
         else if (instruction == 4'hF)                   e = HLT;
      end else if (m_step == 3) begin
         if (instruction == 4'h1)                        e = RO | AI;
         else if (instruction == 4'h2 || instruction == 4'h3) e = RO | BI;
         else if (instruction == 4'h4)                   e = AO | RI;
      end else begin
         if (instruction == 4'h2) e = EO | AI | FI;
         if (instruction == 4'h3) e = EO | AI | FI | SU;
      end
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      if (rst === 1'b1 && !m_halted) begin
         if (m_step == 2 && instruction == 4'hF) m_halted = 1'b1;
         else                                    m_step = (m_step + 1) % 5;
      end
      #1;
   endtask

   task automatic assert_reset();
      rst = 1'b0;
      m_step = 0;
      m_halted = 1'b0;
   endtask

   task automatic test_reset();
      assert_reset();
      for (int i = 0; i < 3; i++) begin
         #1;
         exp_v = model_ctrl();
         vectors++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL reset_hold cyc=%0d got=%b want=%b", i, obs, exp_v);
         end
         tick();
      end
      rst = 1'b1;
      instruction = 4'h0;
      for (int s = 0; s < 5; s++) begin
         #1;
         exp_v = model_ctrl();
         vectors++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL reset_release step=%0d got=%b want=%b", m_step, obs, exp_v);
         end
         tick();
      end
   endtask

   task automatic test_add_sub();
      for (int k = 0; k < 4; k++) begin
         instruction = (k % 2 == 0) ? 4'h2 : 4'h3;
         for (int s = 0; s < 5; s++) begin
            alu_carry = 1'($urandom_range(0, 1));
            alu_zero  = 1'($urandom_range(0, 1));
            #1;
            exp_v = model_ctrl();
            vectors++;
            if (obs !== exp_v) begin
               miscompares++;
               $display("FAIL add_sub op=%h step=%0d got=%b want=%b", instruction, m_step, obs, exp_v);
            end
            tick();
         end
      end
   endtask

   task automatic test_cond_jumps();
      for (int op = 7; op <= 8; op++) begin
         for (int f = 0; f < 2; f++) begin
            instruction = 4'(op);
            alu_carry = (op == 7) ? 1'(f) : 1'($urandom_range(0, 1));
            alu_zero  = (op == 8) ? 1'(f) : 1'($urandom_range(0, 1));
            for (int s = 0; s < 5; s++) begin
               #1;
               exp_v = model_ctrl();
               vectors++;
               if (obs !== exp_v) begin
                  miscompares++;
                  $display("FAIL cond_jump op=%h flag=%0d step=%0d got=%b want=%b",
                           instruction, f, m_step, obs, exp_v);
               end
               if (m_step == 2) begin
                  // Flip the governing flag mid-T2; outputs must follow within the cycle.
                  if (op == 7) alu_carry = ~alu_carry;
                  else         alu_zero  = ~alu_zero;
                  #1;
                  exp_v = model_ctrl();
                  vectors++;
                  if (obs !== exp_v) begin
                     miscompares++;
                     $display("FAIL cond_jump_flip op=%h got=%b want=%b", instruction, obs, exp_v);
                  end
               end
               tick();
            end
         end
      end
   endtask

   task automatic test_sta_out();
      for (int k = 0; k < 2; k++) begin
         instruction = (k == 0) ? 4'h4 : 4'hE;
         for (int s = 0; s < 5; s++) begin
            alu_carry = 1'($urandom_range(0, 1));
            alu_zero  = 1'($urandom_range(0, 1));
            #1;
            exp_v = model_ctrl();
            vectors++;
            if (obs !== exp_v) begin
               miscompares++;
               $display("FAIL sta_out op=%h step=%0d got=%b want=%b", instruction, m_step, obs, exp_v);
            end
            vectors++;
            if ($countones(obs & BUS_DRIVERS) > 1) begin
               miscompares++;
               $display("FAIL bus_drivers op=%h step=%0d got=%b want<=1 driver",
                        instruction, m_step, obs & BUS_DRIVERS);
            end
            tick();
         end
      end
   endtask

   task automatic test_halt();
      instruction = 4'hF;
      for (int c = 0; c < 15; c++) begin
         if (m_halted) begin
            instruction = 4'($urandom_range(0, 15));
            alu_carry   = 1'($urandom_range(0, 1));
            alu_zero    = 1'($urandom_range(0, 1));
         end
         #1;
         exp_v = model_ctrl();
         vectors++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL halt cyc=%0d got=%b want=%b", c, obs, exp_v);
         end
         tick();
      end
      assert_reset();
      #1;
      exp_v = model_ctrl();
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("FAIL halt_reset got=%b want=%b", obs, exp_v);
      end
      tick();
      rst = 1'b1;
      instruction = 4'h0;
      for (int s = 0; s < 5; s++) begin
         #1;
         exp_v = model_ctrl();
         vectors++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL halt_restart step=%0d got=%b want=%b", m_step, obs, exp_v);
         end
         tick();
      end
   endtask

   task automatic test_undef_and_mid_reset();
      instruction = 4'hA;
      for (int s = 0; s < 5; s++) begin
         #1;
         exp_v = model_ctrl();
         vectors++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL undef_op step=%0d got=%b want=%b", m_step, obs, exp_v);
         end
         tick();
      end
      instruction = 4'h1;
      for (int s = 0; s < 4; s++) begin
         #1;
         exp_v = model_ctrl();
         vectors++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL lda_pre_reset step=%0d got=%b want=%b", m_step, obs, exp_v);
         end
         if (s < 3) tick();
      end
      assert_reset();
      for (int c = 0; c < 2; c++) begin
         #1;
         exp_v = model_ctrl();
         vectors++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL lda_mid_reset cyc=%0d got=%b want=%b", c, obs, exp_v);
         end
         tick();
      end
      rst = 1'b1;
      for (int s = 0; s < 5; s++) begin
         #1;
         exp_v = model_ctrl();
         vectors++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL lda_restart step=%0d got=%b want=%b", m_step, obs, exp_v);
         end
         tick();
      end
   endtask

   task automatic test_random_program();
      for (int n = 0; n < 120; n++) begin
         instruction = 4'($urandom_range(0, 15));
         for (int s = 0; s < 5; s++) begin
            alu_carry = 1'($urandom_range(0, 1));
            alu_zero  = 1'($urandom_range(0, 1));
            #1;
            exp_v = model_ctrl();
            vectors++;
            if (obs !== exp_v) begin
               miscompares++;
               $display("FAIL random n=%0d op=%h step=%0d halted=%0d got=%b want=%b",
                        n, instruction, m_step, m_halted, obs, exp_v);
            end
            tick();
         end
         if (m_halted) begin
            assert_reset();
            tick();
            rst = 1'b1;
         end
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_cond_jumps();
      test_sta_out();
      test_halt();
      test_undef_and_mid_reset();
      test_random_program();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout vectors=%0d", vectors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cpu_control.md
Name: cpu_control

Overview:
Microcoded control unit for the 8-bit SAP-style CPU. It decodes the 4-bit opcode from the instruction register and a 3-bit micro-step counter into the one-hot control lines that drive the shared bus, the registers, the ALU, the RAM, the program counter and the output display. Each instruction takes a fixed 5-step cycle, T0 to T4. Conditional jumps use the latched ALU carry and zero flags.

Parameters:
None. Opcodes and step count are fixed constants in the package.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
instruction  input  4  opcode (upper nibble of instruction register)
alu_carry  input  1  latched carry flag
alu_zero  input  1  latched zero flag
clk_halt  output  1  stop the CPU clock (HLT)
pc_inc  output  1  program counter increment
pc_jump  output  1  program counter loads from bus
pc_out  output  1  program counter drives bus
a_reg_read_from_bus  output  1  A register loads from bus
a_reg_write_to_bus  output  1  A register drives bus
b_reg_read_from_bus  output  1  B register loads from bus
b_reg_write_to_bus  output  1  B register drives bus (never asserted by current microcode)
i_reg_read_from_bus  output  1  instruction register loads from bus
i_reg_write_to_bus  output  1  instruction register drives operand nibble onto bus
mar_read_from_bus  output  1  memory address register loads from bus
ram_read_from_bus  output  1  RAM writes bus value at MAR
ram_write_to_bus  output  1  RAM drives bus
alu_out  output  1  ALU result drives bus
alu_subtract  output  1  ALU performs A-B
alu_flags_in  output  1  flags register latches carry and zero
out_en  output  1  output register loads from bus

Behaviour:
- Step counter, 3 bits: T0..T4, advancing on every rising clk. T4 wraps to T0.
- rst low: counter = T0 and halted = 0 immediately; all outputs forced to 0 while rst is low.
- Outputs are combinational from (step, instruction, flags). Other blocks latch on the same rising edge that advances the step.
- Fetch, all opcodes:
  - T0: pc_out, mar_read_from_bus.
  - T1: ram_write_to_bus, i_reg_read_from_bus, pc_inc.
- Execute steps; any signal not listed is 0:
  - NOP 0000: none.
  - LDA 0001: T2 i_reg_write_to_bus + mar_read_from_bus; T3 ram_write_to_bus + a_reg_read_from_bus.
  - ADD 0010: T2 i_reg_write_to_bus + mar_read_from_bus; T3 ram_write_to_bus + b_reg_read_from_bus; T4 alu_out + a_reg_read_from_bus + alu_flags_in.
  - SUB 0011: as ADD, plus alu_subtract in T4.
  - STA 0100: T2 i_reg_write_to_bus + mar_read_from_bus; T3 a_reg_write_to_bus + ram_read_from_bus.
  - LDI 0101: T2 i_reg_write_to_bus + a_reg_read_from_bus.
  - JMP 0110: T2 i_reg_write_to_bus + pc_jump.
  - JC 0111: T2 i_reg_write_to_bus + pc_jump only if alu_carry=1, else nothing.
  - JZ 1000: same as JC, gated by alu_zero.
  - OUT 1110: T2 a_reg_write_to_bus + out_en.
  - HLT 1111: T2 clk_halt.
- Opcodes 1001-1101 execute as NOP.
- Flags are sampled combinationally during T2. A flag change mid-T2 changes the outputs in that same cycle.
- Halt: on the rising edge in T2 with opcode HLT, set sticky halted. While halted, the step is frozen at T2, clk_halt stays 1, and all other outputs are 0. Only rst clears halted.
- Reset mid-instruction aborts it; the first cycle after rst rises is T0.
- At most one bus driver is asserted in any step.

Decomposition:
- Package cpu_pkg holds:
  - opcode enum (OP_NOP..OP_HLT, 4 bits)
  - step enum (T0..T4, 3 bits)
  - packed control-word struct with one bit per output
  - constant FETCH_T0 and FETCH_T1 control words
- One sub-module, cpu_step_counter: step counter plus the halted flag.
- cpu_control contains the decode case statement.

Test Plan:
- Reset: hold rst=0 for 3 cycles → all outputs 0. Release rst → T0 shows pc_out=1 and mar_read_from_bus=1. Next cycle shows ram_write_to_bus, i_reg_read_from_bus and pc_inc = 1.
- ADD (0010): T2 i_reg_write_to_bus + mar_read_from_bus; T3 ram_write_to_bus + b_reg_read_from_bus; T4 alu_out + a_reg_read_from_bus + alu_flags_in with alu_subtract=0. SUB (0011) repeats this with alu_subtract=1 in T4. The next cycle is T0 fetch.
- JC (0111): with alu_carry=0, T2 outputs all 0. With alu_carry=1, T2 has i_reg_write_to_bus=1 and pc_jump=1. Repeat for JZ (1000) using alu_zero.
- STA (0100) then OUT (1110): T3 of STA has a_reg_write_to_bus=1 and ram_read_from_bus=1. T2 of OUT has a_reg_write_to_bus=1 and out_en=1. Every step has at most one bus driver.
- HLT (1111): clk_halt=1 from T2 and stays 1 for 10+ cycles with no other outputs asserted. Pulsing rst=0 clears it, and the next cycle is T0 fetch.
- Opcode 1010 plus reset asserted in T3 of an LDA: 1010 gives all execute steps 0. The mid-LDA reset gives all outputs 0 immediately, then restarts at T0.
